// File: rtl/seven_seg_decode.sv
// Passive monitor for a multiplexed active-low 4-digit seven-segment bus: recovers
// each displayed digit, assembles whole frames and reports them as BCD and binary.
module seven_seg_decode #(
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits,
    output logic [13:0] value,
    output logic        valid,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [7:0]  SETTLE_LIM  = 8'(SETTLE_CYCLES);
    localparam logic [15:0] TIMEOUT_LIM = 16'(FRAME_TIMEOUT);

    logic [1:0]  rst_pipe;
    logic        rst_int_n;
    logic [6:0]  seg_s1, seg_sync;
    logic [3:0]  an_s1, an_sync;
    logic [7:0]  settle_cnt;
    logic        sampled;
    logic        qualified;
    logic [1:0]  idx;
    logic        sample;
    logic [3:0]  glyph_digit;
    logic        glyph_bad;
    logic [3:0]  slot [4];
    logic [3:0]  seen, seen_next;
    logic        bad, bad_next;
    logic [15:0] to_cnt;
    logic        complete;
    logic        timeout;
    logic        err_event;
    logic        err_pend;
    state_t      state;
    logic [1:0]  step;
    logic [15:0] conv_bcd;
    logic [13:0] acc;
    logic [3:0]  cur_digit;

    // Reset asserts asynchronously but releases on a clock edge.
    // NOTE: every clocked block uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_int_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            seg_s1   <= 7'h7F;
            seg_sync <= 7'h7F;
            an_s1    <= 4'hF;
            an_sync  <= 4'hF;
        end else begin
            seg_s1   <= seg_in;
            seg_sync <= seg_s1;
            an_s1    <= an_in;
            an_sync  <= an_s1;
        end
    end

    always_comb begin
        qualified = 1'b1;
        idx       = 2'd0;
        case (an_sync)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: qualified = 1'b0;
        endcase
    end

    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
    always_comb begin
        glyph_bad   = 1'b0;
        glyph_digit = 4'd0;
        case (seg_sync)
            7'b1000000: glyph_digit = 4'd0;
            7'b1111001: glyph_digit = 4'd1;
            7'b0100100: glyph_digit = 4'd2;
            7'b0110000: glyph_digit = 4'd3;
            7'b0011001: glyph_digit = 4'd4;
            7'b0010010: glyph_digit = 4'd5;
            7'b0000010: glyph_digit = 4'd6;
            7'b1111000: glyph_digit = 4'd7;
            7'b0000000: glyph_digit = 4'd8;
            7'b0010000: glyph_digit = 4'd9;
            7'b1111111: glyph_digit = 4'd0;
            default: begin
                glyph_digit = 4'hF;
                glyph_bad   = 1'b1;
            end
        endcase
    end

    // The settle window restarts on the edge where an_sync takes a new value.
    assign sample = (an_s1 == an_sync) && qualified && !sampled &&
                    (settle_cnt + 8'd1 == SETTLE_LIM);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            settle_cnt <= '0;
            sampled    <= 1'b0;
        end else if ((an_s1 != an_sync) || !qualified) begin
            settle_cnt <= '0;
            sampled    <= 1'b0;
        end else if (!sampled) begin
            settle_cnt <= settle_cnt + 8'd1;
            sampled    <= sample;
        end
    end

    assign complete = (seen == 4'hF);
    assign timeout  = (seen != 4'h0) && !complete && !sample &&
                      (to_cnt + 16'd1 == TIMEOUT_LIM);

    always_comb begin
        seen_next = (complete || timeout) ? 4'h0 : seen;
        bad_next  = (complete || timeout) ? 1'b0 : bad;
        if (sample) begin
            seen_next[idx] = 1'b1;
            bad_next       = bad_next | glyph_bad;
        end
    end

    // NOTE: the four slots are only 16 bits, so they are cleared on reset like any other register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < 4; i++) slot[i] <= '0;
            seen   <= '0;
            bad    <= 1'b0;
            to_cnt <= '0;
        end else begin
            if (sample) slot[idx] <= glyph_digit;
            seen <= seen_next;
            bad  <= bad_next;
            if (sample || seen == 4'h0 || complete || timeout) to_cnt <= '0;
            else                                               to_cnt <= to_cnt + 16'd1;
        end
    end

    assign err_event = timeout || (complete && (bad || state != IDLE));

    always_comb begin
        case (step)
            2'd0:    cur_digit = conv_bcd[15:12];
            2'd1:    cur_digit = conv_bcd[11:8];
            2'd2:    cur_digit = conv_bcd[7:4];
            default: cur_digit = conv_bcd[3:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            step      <= '0;
            acc       <= '0;
            conv_bcd  <= '0;
            digits    <= '0;
            value     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            err_pend  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (complete && !bad) begin
                        conv_bcd <= {slot[3], slot[2], slot[1], slot[0]};
                        acc      <= '0;
                        step     <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    // acc*10 + digit, most significant digit first
                    acc <= (acc << 3) + (acc << 1) + {10'd0, cur_digit};
                    if (step == 2'd3) state <= DONE;
                    else              step  <= step + 2'd1;
                end
                DONE: begin
                    value  <= acc;
                    digits <= conv_bcd;
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // An error landing on the valid cycle is held back by one cycle.
            if (state == DONE) begin
                err_pend  <= err_pend | err_event;
                frame_err <= 1'b0;
            end else begin
                frame_err <= err_event | err_pend;
                err_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seven_seg_decode.md
# seven_seg_decode

Monitor that passively samples a multiplexed, active-low 4-digit seven-segment bus (seg/an lines as driven by the board display driver), decodes each glyph back to a BCD digit, assembles a complete 4-digit frame, and converts it to binary. Sits on debug taps beside the display driver, or on external pins of another board, so the displayed number can be self-checked or logged.

## Interface
- SETTLE_CYCLES, 4: clk cycles a digit enable must remain stable before seg is sampled (1..255).
- FRAME_TIMEOUT, 65535: idle clk cycles allowed between samples of a partial frame before it is abandoned (16-bit).
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment lines, active low, seg_in[6]=g … seg_in[0]=a; asynchronous to clk.
- an_in  in  4  digit enables, active low, an_in[0]=ones … an_in[3]=thousands; asynchronous to clk.
- digits  out  16  last good frame as BCD {thousands,hundreds,tens,ones}.
- value  out  14  last good frame as binary, 0..9999.
- valid  out  1  one-cycle pulse when digits/value update.
- frame_err  out  1  one-cycle pulse on bad glyph or timeout.
- busy  out  1  high while conversion runs.

## Operation
- seg_in and an_in each pass through a 2-flop synchronizer; all logic below uses synchronized copies.
- Enable qualify: an_sync must have exactly one bit low; 1111 or multiple low bits = idle, no sampling, settle counter cleared.
- Settle counter: clears when an_sync changes; increments while stable and qualified; at count == SETTLE_CYCLES, seg_sync is sampled once. No further samples until an_sync changes.
- Glyph decode (7-bit, g..a): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 1111111 (blank)=0. Any other pattern: slot stored as 4'hF and frame bad flag set.
- Sample writes slot indexed by the low bit of an_sync and sets seen[idx]. Re-sampling a slot before completion overwrites it; seen unchanged.
- Frame complete when seen == 1111: slots snapshotted into conversion registers, seen and bad cleared same edge. Capture continues concurrently into slots.
- If bad was set at completion: frame_err pulse, no conversion, digits/value hold.
- Conversion FSM: IDLE → CONV (4 steps: acc = acc*10 + slot, thousands first; acc 14 bits, no overflow since max 9999) → DONE (register value/digits, pulse valid) → IDLE. busy high in CONV and DONE.
- A frame completing while busy is dropped and pulses frame_err.
- Timeout: while seen != 0000, counter counts cycles since last sample; reaching FRAME_TIMEOUT clears seen and bad and pulses frame_err. Counter clears on every sample and when seen == 0000.
- frame_err and valid never assert in the same cycle; if both events coincide, frame_err is delayed one cycle.

## Timing
- Reset (async assert, sync deassert internally): digits=0, value=0, valid=0, frame_err=0, busy=0, FSM IDLE, seen=0000, counters 0, synchronizers 1111111/1111.
- an_in edge to sample: 2 (sync) + SETTLE_CYCLES clk edges.
- Sample of final digit at edge S; snapshot at S+1; CONV steps at S+2..S+5; digits/value/valid registered at S+6; valid high exactly one cycle.
- bad-glyph frame_err registered at S+1; timeout frame_err the edge the counter reaches FRAME_TIMEOUT.
- Reset mid-conversion: outputs return to reset values immediately; partial result discarded.

## Test plan
- Drive 1,2,3,4 glyphs on an=0111/1011/1101/1110, 20 cycles each, SETTLE_CYCLES=4 → valid once, digits=16'h1234, value=1234, 6 edges after fourth sample.
- Drive 9,9,9,9 then 0,0,0,0 → value=9999 then value=0; blank glyph in thousands with 0,4,2 → value=42.
- Tens glyph 0101010 in otherwise valid frame → frame_err one cycle, no valid, value keeps previous.
- an pulse of 3 cycles (< 2+SETTLE_CYCLES) with wrong glyph inside valid frame → ignored, correct value reported.
- FRAME_TIMEOUT=100: sample three digits, then an=1111 for 120 cycles → frame_err at 100th idle cycle; subsequent full frame decodes correctly.
- Assert rst_n low during CONV → busy=0, valid never pulses, value=0; next full frame decodes normally.
